instr_exec_sequencer: RTL
=========================

INSTR_EXEC_SEQUENCER -- requirements
Module: instr_exec_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk sampled on the rising edge, reset_n active-low synchronous.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  request to execute a run of instructions
- base_ptr  in  5  first register location of the run
- count  in  6  number of instructions, 0..63
- abort  in  1  cancel the current run
- read_pointer  out  5  address to the instruction register (combinational read)
- iw_opc  in  3  opcode at read_pointer: 0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD
- iw_op_a  in  32  signed operand A at read_pointer
- iw_op_b  in  32  signed operand B at read_pointer
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_ptr  out  5  location the result came from
- res_opc  out  3  opcode of the result
- res_value  out  64  signed result
- res_dbz  out  1  divide or modulo by zero
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at normal end of run

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, EXEC, HOLD.
REQ-004 In IDLE, start=1 with count>0 SHALL latch base_ptr into an internal pointer and count into a remaining counter, then go to FETCH; busy=1 from the next cycle.
REQ-005 In IDLE, start=1 with count=0 SHALL do no reads, stay in IDLE and pulse done in the next cycle.
REQ-006 start SHALL be ignored whenever busy=1.
REQ-007 In FETCH, read_pointer SHALL equal the internal pointer, and iw_opc, iw_op_a and iw_op_b SHALL be captured at the end of the cycle; the next state is EXEC.
REQ-008 In EXEC, the result SHALL be computed from the captured operands and registered into res_value, res_opc, res_ptr and res_dbz; the next state is HOLD.
REQ-009 Arithmetic SHALL sign-extend both operands to 64 bits and compute:
- ZERO gives 0
- PASSA gives a
- PASSB gives b
- ADD gives a+b
- SUB gives a-b
- MULT gives a*b (full 64-bit product, no overflow)
- DIV gives a/b, truncated toward zero
- MOD gives a%b, with the sign of a
REQ-010 DIV or MOD with b=0 SHALL give res_value=0 and res_dbz=1; in all other cases res_dbz=0.
REQ-011 The case a=-2^31, b=-1 for DIV SHALL give +2^31 (no overflow in 64 bits).
REQ-012 In HOLD, res_valid=1 and all res_* outputs SHALL stay stable until res_ready=1; res_valid is 0 in all other states.
REQ-013 On a HOLD handshake, remaining SHALL decrement and the pointer SHALL increment modulo 32 (31 wraps to 0).
REQ-014 On the HOLD handshake: if remaining was >1, the next state is FETCH; otherwise the next state is IDLE, busy=0, and done=1 for exactly that next cycle.
REQ-015 Minimum latency SHALL be: start sampled at edge N; FETCH during cycle N+1; EXEC during N+2; res_valid high in N+3. Maximum throughput is one result per 3 cycles.
REQ-016 count>32 SHALL wrap and re-read locations, with no special handling.
REQ-017 abort=1 in any non-IDLE state SHALL return the FSM to IDLE at the next edge, with res_valid=0, busy=0 and no done pulse.
REQ-018 abort SHALL take priority over a same-cycle handshake; that result counts as not delivered.
REQ-019 read_pointer SHALL hold its last value outside FETCH.
REQ-020 The block SHALL never write to the instruction register.

Reset
REQ-021 When reset_n=0 at a rising edge, the block SHALL, at that edge:
- go to IDLE
- set read_pointer=0, res_valid=0, res_ptr=0, res_opc=0, res_value=0, res_dbz=0, busy=0, done=0
- clear the internal pointer and remaining counter
REQ-022 Reset SHALL take priority over start, abort and res_ready, including in the middle of a run.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single ADD: base_ptr=3, count=1, loc3={ADD,-7,5}, res_ready=1 -> res_valid high 3 cycles after start; res_value=-2, res_ptr=3; done pulses one cycle after the handshake.
- Wrap and backpressure: base_ptr=30, count=4, res_ready low 2 cycles per result -> read_pointer sequence 30,31,0,1; each result held stable while stalled.
- Divide by zero: loc0={DIV,9,0} then loc1={MOD,-7,2} -> first res_value=0, res_dbz=1; second res_value=-1, res_dbz=0.
- Edge arithmetic: {MULT,-2^31,-2^31} -> 2^62; {DIV,-2^31,-1} -> 2^31.
- count=0 and busy start: count=0 -> done next cycle with no FETCH. A start during a run -> ignored; base_ptr is unchanged mid-run.
- Abort and reset: abort in HOLD with res_ready=1 -> IDLE, no done. reset_n=0 in EXEC -> all outputs at reset values at the next edge.

Source files
------------

// File: rtl/instr_exec_sequencer.sv
// instr_exec_sequencer: fetches a run of instructions from an external register file,
// executes each one on signed 64-bit arithmetic and hands the results out one at a time.
module instr_exec_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [4:0]  base_ptr,
  input  logic [5:0]  count,
  input  logic        abort,
  output logic [4:0]  read_pointer,
  input  logic [2:0]  iw_opc,
  input  logic [31:0] iw_op_a,
  input  logic [31:0] iw_op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [4:0]  res_ptr,
  output logic [2:0]  res_opc,
  output logic [63:0] res_value,
  output logic        res_dbz,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HOLD} state_e;
  state_e state_q, state_d;
  logic [4:0] ptr_q, ptr_d, rp_q, rp_d;
  logic [5:0] rem_q, rem_d;
  logic [2:0] opc_q;
  logic [31:0] a_q, b_q;
  logic done_q, done_d;
  logic signed [63:0] sa, sb, value;
  logic dz;
  assign sa = {{32{a_q[31]}}, a_q};
  assign sb = {{32{b_q[31]}}, b_q};
  assign dz = (opc_q[2:1] == 2'b11) && (b_q == 32'd0);
  always_comb begin
    value = opc_q == 3'd0 ? 64'sd0 :
            opc_q == 3'd1 ? sa :
            opc_q == 3'd2 ? sb :
            opc_q == 3'd3 ? sa + sb :
            opc_q == 3'd4 ? sa - sb :
            opc_q == 3'd5 ? sa * sb :
            dz            ? 64'sd0 :
            opc_q == 3'd6 ? sa / sb : sa % sb;
  end
  // Abort wins over everything, including a handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    rp_d    = rp_q;
    done_d  = 1'b0;
    if (abort && state_q != IDLE) state_d = IDLE;
    else
      case (state_q)
        IDLE: if (start) begin
          if (count != 6'd0) begin
            ptr_d   = base_ptr;
            rem_d   = count;
            state_d = FETCH;
          end else done_d = 1'b1;
        end
        FETCH: begin
          rp_d    = ptr_q;
          state_d = EXEC;
        end
        EXEC: state_d = HOLD;
        HOLD: if (res_ready) begin
          ptr_d   = ptr_q + 5'd1;
          rem_d   = rem_q - 6'd1;
          state_d = rem_q > 6'd1 ? FETCH : IDLE;
          done_d  = rem_q <= 6'd1;
        end
      endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      rp_q      <= '0;
      done_q    <= 1'b0;
      opc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_ptr   <= '0;
      res_opc   <= '0;
      res_value <= '0;
      res_dbz   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      rp_q    <= rp_d;
      done_q  <= done_d;
      if (state_q == FETCH) begin
        opc_q <= iw_opc;
        a_q   <= iw_op_a;
        b_q   <= iw_op_b;
      end
      if (state_q == EXEC && !abort) begin
        res_ptr   <= rp_q;
        res_opc   <= opc_q;
        res_value <= value;
        res_dbz   <= dz;
      end
    end
  end
  assign read_pointer = state_q == FETCH ? ptr_q : rp_q;
  assign res_valid    = state_q == HOLD;
  assign busy         = state_q != IDLE;
  assign done         = done_q;
endmodule
